// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative signed/unsigned divider, one non-restoring step per
//                cycle; returns {remainder, quotient} with a divide-by-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] z,
    output logic               busy,
    output logic               ready,
    output logic               div_zero
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvs;
    logic                 r_signed;
    logic                 r_dvd_neg;
    logic                 r_dvs_neg;
    logic                 r_dz;
    logic [2*WIDTH-1:0]   r_z;
    logic                 r_busy;
    logic                 r_ready;
    logic                 r_div_zero;

    logic                 w_capture;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_last;

    logic                 w_dvd_neg_in;
    logic                 w_dvs_neg_in;
    logic [WIDTH-1:0]     w_dvd_mag;
    logic [WIDTH-1:0]     w_dvs_mag;

    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_rem_step;
    logic [WIDTH-1:0]     w_quo_step;

    logic [WIDTH-1:0]     w_rem_mag;
    logic [WIDTH-1:0]     w_rem_res;
    logic [WIDTH-1:0]     w_quo_res;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last = (r_count == c_CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_ITER;
                end
            end
            ST_ITER: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_finish     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning: magnitudes only in signed mode
    // ------------------------------------------------------------------
    assign w_dvd_neg_in = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg_in = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag    = w_dvd_neg_in ? -dividend : dividend;
    assign w_dvs_mag    = w_dvs_neg_in ? -divisor  : divisor;

    // A negative partial remainder adds the divisor back in the next step
    // instead of restoring, so each step costs a single add/subtract.
    assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_rem_step = r_rem[WIDTH] ? (w_shift + {1'b0, r_dvs})
                                     : (w_shift - {1'b0, r_dvs});
    assign w_quo_step = {r_quo[WIDTH-2:0], ~w_rem_step[WIDTH]};

    // Final correction; the corrected remainder always lies in [0, divisor).
    assign w_rem_mag = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_dvs) : r_rem[WIDTH-1:0];
    assign w_rem_res = (r_signed & r_dvd_neg) ? -w_rem_mag : w_rem_mag;
    assign w_quo_res = r_dz                                ? '1
                     : (r_signed & (r_dvd_neg ^ r_dvs_neg)) ? -r_quo
                     :                                        r_quo;

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_signed   <= 1'b0;
            r_dvd_neg  <= 1'b0;
            r_dvs_neg  <= 1'b0;
            r_dz       <= 1'b0;
            r_z        <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_capture) begin
                r_signed   <= is_signed;
                r_dvd_neg  <= dividend[WIDTH-1];
                r_dvs_neg  <= divisor[WIDTH-1];
                r_dz       <= (divisor == '0);
                r_quo      <= w_dvd_mag;
                r_dvs      <= w_dvs_mag;
                r_rem      <= '0;
                r_count    <= '0;
                r_busy     <= 1'b1;
                r_ready    <= 1'b0;
                r_div_zero <= 1'b0;
            end
            if (w_step) begin
                r_rem   <= w_rem_step;
                r_quo   <= w_quo_step;
                r_count <= w_last ? '0 : (r_count + c_CNT_ONE);
            end
            if (w_finish) begin
                r_z        <= {w_rem_res, w_quo_res};
                r_busy     <= 1'b0;
                r_ready    <= 1'b1;
                r_div_zero <= r_dz;
            end
        end
    end

    assign z        = r_z;
    assign busy     = r_busy;
    assign ready    = r_ready;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit (WIDTH 32 and 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [63:0] z;
    logic        busy;
    logic        ready;
    logic        div_zero;

    logic        start8 = 1'b0;
    logic        is_signed8 = 1'b0;
    logic [7:0]  dividend8 = '0;
    logic [7:0]  divisor8 = '0;
    logic [15:0] z8;
    logic        busy8;
    logic        ready8;
    logic        div_zero8;

    int n_assert = 0;
    int n_fail   = 0;
    int edges;
    int seen;

    always #5 clock = ~clock;

    div_unit #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .z(z), .busy(busy),
        .ready(ready), .div_zero(div_zero)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(is_signed8),
        .dividend(dividend8), .divisor(divisor8), .z(z8), .busy(busy8),
        .ready(ready8), .div_zero(div_zero8)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One full 32-bit operation; operands are scrambled right after capture.
    task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_z, input logic exp_dz);
        int n;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = ~sgn;
        check1({tag, "_busy_on"}, busy, 1'b1);
        check1({tag, "_ready_off"}, ready, 1'b0);
        check1({tag, "_dz_clear"}, div_zero, 1'b0);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        checki({tag, "_latency"}, n, 33);
        check64({tag, "_z"}, z, exp_z);
        check1({tag, "_dz"}, div_zero, exp_dz);
        check1({tag, "_busy_off"}, busy, 1'b0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check1("rst_busy", busy, 1'b0);
        check1("rst_ready", ready, 1'b0);
        check1("rst_dz", div_zero, 1'b0);
        check64("rst_z", z, 64'h0);
        check1("rst_busy8", busy8, 1'b0);
        check16("rst_z8", z8, 16'h0);

        // Release reset and start on the very next edge
        reset = 1'b1;
        run32("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);

        // Result holds while idle
        repeat (3) tick();
        check64("hold_z", z, {32'h0000_0001, 32'hFFFF_FFFD});
        check1("hold_ready", ready, 1'b1);

        run32("u_ff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'h7FFF_FFFF}, 1'b0);
        run32("s_ff_2", 1'b1, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'h0000_0000}, 1'b0);
        run32("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0);
        run32("s_dz", 1'b1, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1);
        run32("s_dz_neg", 1'b1, 32'hFFFF_FF00, 32'h0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1'b1);
        run32("u_dz", 1'b0, 32'h8000_0001, 32'h0, {32'h8000_0001, 32'hFFFF_FFFF}, 1'b1);
        run32("u_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        run32("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);
        run32("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 1'b0);
        run32("u_80_ff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 1'b0);

        // Start pulse mid-operation is ignored
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        repeat (5) begin
            tick();
            edges++;
        end
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        tick();
        edges++;
        start = 1'b0;
        check1("ign_busy", busy, 1'b1);
        check64("ign_z_frozen", z, {32'h8000_0000, 32'h0000_0000});
        while (!ready && edges < 200) begin
            tick();
            edges++;
        end
        checki("ign_latency", edges, 33);
        check64("ign_z", z, {32'd1, 32'd333});

        // Reset at iteration 10 aborts without a ready pulse
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_ready", ready, 1'b0);
        check64("abort_z", z, 64'h0);
        tick();
        tick();
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (ready) seen = 1;
        end
        checki("abort_no_ready", seen, 0);
        run32("after_abort", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0);

        // WIDTH=8: -128/3, then back-to-back 100/-7 started on the ready cycle
        is_signed8 = 1'b1;
        dividend8  = 8'h80;
        divisor8   = 8'd3;
        start8     = 1'b1;
        tick();
        start8 = 1'b0;
        edges  = 0;
        while (!ready8 && edges < 100) begin
            tick();
            edges++;
        end
        checki("w8_latency", edges, 9);
        check16("w8_z", z8, 16'hFED6);
        check1("w8_dz", div_zero8, 1'b0);
        dividend8 = 8'd100;
        divisor8  = 8'hF9;
        start8    = 1'b1;
        tick();
        start8 = 1'b0;
        check1("w8_b2b_ready_drop", ready8, 1'b0);
        check1("w8_b2b_busy", busy8, 1'b1);
        check16("w8_b2b_z_held", z8, 16'hFED6);
        edges = 0;
        while (!ready8 && edges < 100) begin
            tick();
            edges++;
        end
        checki("w8_b2b_latency", edges, 9);
        check16("w8_b2b_z", z8, 16'h02F2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/quotient/remainder width (legal: 4..64, even).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port is_signed  input  1  1=two's-complement divide, 0=unsigned; captured with start.
REQ-007 SHALL have port dividend  input  WIDTH  numerator; captured with start.
REQ-008 SHALL have port divisor  input  WIDTH  denominator; captured with start.
REQ-009 SHALL have port z  output  2*WIDTH  {remainder, quotient}: remainder in upper half, quotient in lower half.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port ready  output  1  z valid for last accepted operation.
REQ-012 SHALL have port div_zero  output  1  last accepted operation had divisor==0.

Function
REQ-013 SHALL implement states IDLE, ITER, FIX.
- IDLE + start=1 -> ITER.
- ITER, after WIDTH iterations -> FIX.
- FIX -> IDLE.
REQ-014 On the capture edge (IDLE, start=1), SHALL:
- latch is_signed, both operand signs and divisor==0;
- load |dividend| and |divisor| (magnitude only when is_signed=1, raw otherwise);
- clear partial remainder and iteration counter;
- set busy=1, ready=0.
REQ-015 In ITER, SHALL perform one non-restoring step per cycle over a WIDTH+1-bit partial remainder:
- sign of the partial remainder selects add or subtract of the divisor;
- quotient bit = inverted new sign;
- counter wraps exactly after WIDTH steps.
REQ-016 In FIX, SHALL complete the operation in one cycle:
- add the divisor back if the partial remainder is negative;
- when signed, negate the quotient if the operand signs differ;
- when signed, negate the remainder if the dividend was negative;
- register z;
- set busy=0, ready=1, div_zero=latched flag.
REQ-017 Latency SHALL be exactly WIDTH+1 rising edges from the capture edge to the edge that asserts ready; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-018 z, ready and div_zero SHALL hold until the next capture edge, which clears ready and div_zero; z SHALL NOT change while busy=1.
REQ-019 start while busy=1 SHALL be ignored: no restart and no operand re-capture.
REQ-020 start=1 in a cycle with ready=1 and busy=0 SHALL be accepted as a new capture.
REQ-021 Quotient SHALL truncate toward zero; the remainder SHALL take the dividend's sign.
REQ-022 On divisor==0, SHALL take full latency and return quotient all-ones and remainder equal to the raw dividend, with div_zero=1, independent of mode.
REQ-023 On signed overflow (dividend=most-negative, divisor=-1), SHALL return quotient = most-negative and remainder = 0, with no flag.
REQ-024 Operand inputs MAY change after the capture edge without affecting the result.

Reset
REQ-025 While reset=0, asynchronously and regardless of state, SHALL force:
- state=IDLE, busy=0, ready=0, div_zero=0;
- z=0, counter=0, internal registers=0.
REQ-026 Reset during ITER/FIX SHALL abort the operation, producing no ready pulse.
REQ-027 The first rising edge after reset returns to 1 SHALL accept a start.

Verification
REQ-028 WIDTH=32, signed, 7 / -2 -> after 33 edges: ready=1, z={0x00000001, 0xFFFFFFFD}, div_zero=0.
REQ-029 WIDTH=32, dividend 0xFFFFFFFF, divisor 2:
- unsigned -> z={0x00000001, 0x7FFFFFFF};
- signed -> z={0xFFFFFFFF, 0x00000000}.
REQ-030 WIDTH=32, signed:
- 0x80000000 / 0xFFFFFFFF -> z={0x00000000, 0x80000000};
- 0x12345678 / 0 -> z={0x12345678, 0xFFFFFFFF}, div_zero=1.
REQ-031 WIDTH=32, start pulsed with new operands at iteration 5 -> ignored, original result delivered on schedule; reset=0 at iteration 10 -> busy/ready/z immediately 0, no ready; next start completes normally.
REQ-032 WIDTH=8, signed, -128 / 3 -> after 9 edges z={0xFE, 0xD6}; back-to-back start on the ready cycle -> ready drops next edge, second result 9 edges later.
